// File: rtl/ctrl_hazard_tracker_pkg.sv
// Shared encodings for the hazard tracker.
//   FWD_*     : forwarding-select encoding used on every FWD_* output
//   TUSE_NONE : Tuse value meaning "operand not read" (never stalls)
package ctrl_hazard_tracker_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;  // register file / pipe register
  localparam logic [1:0] FWD_E   = 2'd1;  // E-stage result
  localparam logic [1:0] FWD_M   = 2'd2;  // M-stage result
  localparam logic [1:0] FWD_W   = 2'd3;  // W-stage write data

  localparam logic [1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/ctrl_hazard_stage.sv
// One shadow pipeline slice: {rt, A3, Tnew}.
//   clk, reset : clock, async active-high reset (clears all fields)
//   clear      : load an all-zero bubble instead of the inputs
//   in_*       : fields from the previous stage
//   q_*        : registered fields
// With DEC set, Tnew is saturating-decremented on the way in. This models
// one cycle of progress through the pipe.
module ctrl_hazard_stage #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter bit DEC   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [REG_W-1:0] in_rt,
  input  logic [REG_W-1:0] in_a3,
  input  logic [T_W-1:0]   in_tnew,
  output logic [REG_W-1:0] q_rt,
  output logic [REG_W-1:0] q_a3,
  output logic [T_W-1:0]   q_tnew
);

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_rt   <= '0;
      q_a3   <= '0;
      q_tnew <= '0;
    end else if (clear) begin
      q_rt   <= '0;
      q_a3   <= '0;
      q_tnew <= '0;
    end else begin
      q_rt   <= in_rt;
      q_a3   <= in_a3;
      q_tnew <= DEC ? sat_dec(in_tnew) : in_tnew;
    end
  end

endmodule

// File: rtl/ctrl_hazard_tracker.sv
// Hazard tracker. It shadows the E/M/W pipeline and produces the stall signal
// and the forwarding selects.
//   clk, reset         : clock, async active-high reset
//   D_rs/D_rt          : source registers of the D instruction
//   D_Tuse_rs/rt       : cycles until D needs each source (3 = unused)
//   D_A3/D_Tnew        : destination and result latency of the D instruction
//   stall / E_clear    : freeze F/D and inject a bubble into D/E
//   FWD_D_rs/rt        : D-stage operand source
//   FWD_E_rs/rt        : E-stage ALU operand source
//   FWD_M_rt           : M-stage store-data source
//   stall_cnt          : saturating count of stalled cycles
module ctrl_hazard_tracker
  import ctrl_hazard_tracker_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [T_W-1:0]   D_Tuse_rs,
  input  logic [T_W-1:0]   D_Tuse_rt,
  input  logic [REG_W-1:0] D_A3,
  input  logic [T_W-1:0]   D_Tnew,
  output logic             stall,
  output logic             E_clear,
  output logic [1:0]       FWD_D_rs,
  output logic [1:0]       FWD_D_rt,
  output logic [1:0]       FWD_E_rs,
  output logic [1:0]       FWD_E_rt,
  output logic [1:0]       FWD_M_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [REG_W-1:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
  logic [T_W-1:0]   e_tnew, m_tnew;

  // E.rs is only needed in E, so it sits outside the shared slice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      e_rs <= '0;
    else if (stall) e_rs <= '0;
    else            e_rs <= D_rs;
  end

  ctrl_hazard_stage #(.REG_W(REG_W), .T_W(T_W), .DEC(1'b0)) u_e (
    .clk(clk), .reset(reset), .clear(stall),
    .in_rt(D_rt), .in_a3(D_A3), .in_tnew(D_Tnew),
    .q_rt(e_rt), .q_a3(e_a3), .q_tnew(e_tnew)
  );

  ctrl_hazard_stage #(.REG_W(REG_W), .T_W(T_W), .DEC(1'b1)) u_m (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_rt(e_rt), .in_a3(e_a3), .in_tnew(e_tnew),
    .q_rt(m_rt), .q_a3(m_a3), .q_tnew(m_tnew)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_a3 <= '0;
    else       w_a3 <= m_a3;
  end

  // $0 is never a hazard. A3 == 0 therefore never matches.
  function automatic logic hit(input logic [REG_W-1:0] src,
                               input logic [REG_W-1:0] a3);
    return (src != '0) && (a3 == src);
  endfunction

  // The nearer producer owns the register. A match in E hides any match
  // in M, and this holds for both the stall and the forwarding decision.
  function automatic logic stall_src(input logic [REG_W-1:0] src,
                                     input logic [T_W-1:0]   tuse);
    if (hit(src, e_a3))      return tuse < e_tnew;
    else if (hit(src, m_a3)) return tuse < m_tnew;
    else                     return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_d(input logic [REG_W-1:0] src);
    if (hit(src, e_a3))      return (e_tnew == '0) ? FWD_E : FWD_GRF;
    else if (hit(src, m_a3)) return (m_tnew == '0) ? FWD_M : FWD_GRF;
    else if (hit(src, w_a3)) return FWD_W;
    else                     return FWD_GRF;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src);
    if (hit(src, m_a3))      return (m_tnew == '0) ? FWD_M : FWD_GRF;
    else if (hit(src, w_a3)) return FWD_W;
    else                     return FWD_GRF;
  endfunction

  always_comb begin
    stall    = stall_src(D_rs, D_Tuse_rs) | stall_src(D_rt, D_Tuse_rt);
    E_clear  = stall;
    FWD_D_rs = fwd_d(D_rs);
    FWD_D_rt = fwd_d(D_rt);
    FWD_E_rs = fwd_e(e_rs);
    FWD_E_rt = fwd_e(e_rt);
    FWD_M_rt = hit(m_rt, w_a3) ? FWD_W : FWD_GRF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ctrl_hazard_tracker.sv
module tb_ctrl_hazard_tracker;
  import ctrl_hazard_tracker_pkg::*;

  localparam int CW = 3;  // narrow counter so saturation is reachable

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       stall, E_clear;
  logic [1:0] FWD_D_rs, FWD_D_rt, FWD_E_rs, FWD_E_rt, FWD_M_rt;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_hazard_tracker #(.REG_W(5), .T_W(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_A3(D_A3), .D_Tnew(D_Tnew),
    .stall(stall), .E_clear(E_clear),
    .FWD_D_rs(FWD_D_rs), .FWD_D_rt(FWD_D_rt),
    .FWD_E_rs(FWD_E_rs), .FWD_E_rt(FWD_E_rt), .FWD_M_rt(FWD_M_rt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one D-stage instruction and let combinational outputs settle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tn);
    D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
    D_A3 = a3; D_Tnew = tn;
    #1;
  endtask

  task automatic nop();      drive(0, 0, TUSE_NONE, TUSE_NONE, 0, 0); endtask
  task automatic lw8();      drive(29, 0, 1, TUSE_NONE, 8, 2);       endtask
  task automatic beq8();     drive(8, 0, 0, 0, 0, 0);                endtask

  task automatic apply_reset();
    reset = 1'b1;
    nop();
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall); end
    n_checks++; if (E_clear !== 1'b0) begin n_fail++; $display("FAIL reset_eclear got %0d exp 0", E_clear); end
    n_checks++; if ({FWD_D_rs, FWD_D_rt, FWD_E_rs, FWD_E_rt, FWD_M_rt} !== 10'd0) begin
      n_fail++; $display("FAIL reset_fwd got %b exp 0", {FWD_D_rs, FWD_D_rt, FWD_E_rs, FWD_E_rt, FWD_M_rt}); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive(29, 0, 1, TUSE_NONE, 5, 2);   // lw $5
    tick();
    drive(5, 0, 0, TUSE_NONE, 0, 0);    // reader of $5 with Tuse 0
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_stall got %0d exp 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got %0d exp 0", stall); end
    n_checks++; if ({FWD_D_rs, FWD_D_rt, FWD_E_rs, FWD_E_rt, FWD_M_rt} !== 10'd0) begin
      n_fail++; $display("FAIL midrst_fwd got %b exp 0", {FWD_D_rs, FWD_D_rt, FWD_E_rs, FWD_E_rt, FWD_M_rt}); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    lw8();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall got %0d exp 0", stall); end
    tick();
    drive(8, 8, 1, 1, 9, 1);            // addu $9,$8,$8
    n_checks++; if (stall !== 1'b1 || E_clear !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall1 got %0d/%0d exp 1/1", stall, E_clear); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2 got %0d exp 0", stall); end
    tick();
    nop();
    n_checks++; if (FWD_E_rs !== FWD_W || FWD_E_rt !== FWD_W) begin
      n_fail++; $display("FAIL lu_fwd_e got %0d/%0d exp 3/3", FWD_E_rs, FWD_E_rt); end
    n_checks++; if (stall_cnt !== 3'd1) begin n_fail++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_branch_load();
    apply_reset();
    lw8();
    tick();
    beq8();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL br_stall1 got %0d exp 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL br_stall2 got %0d exp 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall3 got %0d exp 0", stall); end
    n_checks++; if (FWD_D_rs !== FWD_W || FWD_D_rt !== FWD_GRF) begin
      n_fail++; $display("FAIL br_fwd_d got %0d/%0d exp 3/0", FWD_D_rs, FWD_D_rt); end
    tick();
    nop();
    n_checks++; if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL br_cnt got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_store_fwd();
    apply_reset();
    drive(1, 2, 1, 1, 8, 1);            // addu $8,$1,$2
    tick();
    drive(9, 8, 1, 2, 0, 0);            // sw $8,0($9)
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall got %0d exp 0", stall); end
    n_checks++; if (FWD_D_rt !== FWD_GRF) begin n_fail++; $display("FAIL st_fwd_d got %0d exp 0", FWD_D_rt); end
    tick();
    nop();
    n_checks++; if (FWD_E_rt !== FWD_M || FWD_E_rs !== FWD_GRF) begin
      n_fail++; $display("FAIL st_fwd_e got %0d/%0d exp 2/0", FWD_E_rt, FWD_E_rs); end
    tick();
    n_checks++; if (FWD_M_rt !== FWD_W) begin n_fail++; $display("FAIL st_fwd_m got %0d exp 3", FWD_M_rt); end
  endtask

  task automatic test_jal_jr();
    apply_reset();
    drive(0, 0, TUSE_NONE, TUSE_NONE, 31, 0);  // jal
    tick();
    drive(31, 0, 0, TUSE_NONE, 0, 0);          // jr $31
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jr_stall got %0d exp 0", stall); end
    n_checks++; if (FWD_D_rs !== FWD_E) begin n_fail++; $display("FAIL jr_fwd_d got %0d exp 1", FWD_D_rs); end
    tick();
    nop();
    n_checks++; if (FWD_E_rs !== FWD_M) begin n_fail++; $display("FAIL jr_fwd_e got %0d exp 2", FWD_E_rs); end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    drive(1, 2, 1, 1, 0, 1);            // addu $0,$1,$2
    tick();
    drive(29, 0, 1, TUSE_NONE, 0, 2);   // lw $0
    tick();
    drive(0, 0, 0, 0, 9, 1);            // reader of $0
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL z_stall got %0d exp 0", stall); end
    n_checks++; if (FWD_D_rs !== 2'd0 || FWD_D_rt !== 2'd0) begin
      n_fail++; $display("FAIL z_fwd_d got %0d/%0d exp 0/0", FWD_D_rs, FWD_D_rt); end
    tick();
    nop();
    n_checks++; if (FWD_E_rs !== 2'd0 || FWD_E_rt !== 2'd0) begin
      n_fail++; $display("FAIL z_fwd_e got %0d/%0d exp 0/0", FWD_E_rs, FWD_E_rt); end
    tick();
    n_checks++; if (FWD_M_rt !== 2'd0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL z_fwd_m_cnt got %0d/%0d exp 0/0", FWD_M_rt, stall_cnt); end
  endtask

  // Each lw/beq pair costs two stall cycles. Four pairs reach 8, which clips to 7.
  task automatic test_cnt_saturate();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      lw8();  tick();
      beq8(); tick(); tick(); tick();
      if (k == 2) begin
        n_checks++; if (stall_cnt !== 3'd6) begin n_fail++; $display("FAIL sat_mid got %0d exp 6", stall_cnt); end
      end
    end
    nop();
    n_checks++; if (stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_end got %0d exp 7", stall_cnt); end
  endtask

  initial begin
    nop();
    test_reset();
    test_mid_reset();
    test_load_use();
    test_branch_load();
    test_store_fwd();
    test_jal_jr();
    test_zero_reg();
    test_cnt_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
